// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/ack, branch redirect,
// and the decoded instruction handed downstream with valid/ready.
interface inst_fetch_if #(
    parameter int CNT_W = 32
) ();
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm16;
    logic [CNT_W-1:0]  fetch_cnt;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc, out_instr, op, rs, rt, rd, shamt, funct, imm16, fetch_cnt
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc, out_instr, op, rs, rt, rd, shamt, funct, imm16, fetch_cnt
    );
endinterface

// File: rtl/inst_fetch.sv
// MIPS instruction fetch stage: PC register, memory request FSM with
// redirect handling, instruction register and decoder field slices.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_if.master  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [31:0]      pc_r;
    logic [31:0]      pc_s;
    logic [31:0]      addr_r;
    logic             req_r;
    logic             valid_r;
    logic [31:0]      instr_r;
    logic [31:0]      opc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             capture_s;
    logic             xfer_s;
    logic [31:0]      redir_s;

    assign redir_s = bus.redirect_pc & 32'hFFFF_FFFC;

    // Next-state, next-PC and capture/transfer decode.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        capture_s = 1'b0;
        xfer_s    = 1'b0;
        case (state_r)
            IDLE: begin
                state_s = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    if (bus.redirect) begin
                        pc_s = redir_s;
                    end else begin
                        capture_s = 1'b1;
                        pc_s      = pc_r + 32'd4;
                        state_s   = HOLD;
                    end
                end else if (bus.redirect) begin
                    pc_s    = redir_s;
                    state_s = DROP;
                end else begin
                    state_s = FETCH;
                end
            end
            DROP: begin
                // The outstanding request must still complete; only its data is discarded.
                if (bus.redirect) begin
                    pc_s = redir_s;
                end else begin
                    pc_s = pc_r;
                end
                if (bus.imem_ack) begin
                    state_s = FETCH;
                end else begin
                    state_s = DROP;
                end
            end
            HOLD: begin
                xfer_s = bus.out_ready;
                if (bus.redirect) begin
                    pc_s    = redir_s;
                    state_s = FETCH;
                end else if (bus.out_ready) begin
                    state_s = FETCH;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, PC, address latch, registered handshake outputs and counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            addr_r  <= RESET_PC;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
            instr_r <= 32'h0000_0000;
            opc_r   <= 32'h0000_0000;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            req_r   <= (state_s == FETCH) || (state_s == DROP);
            valid_r <= (state_s == HOLD);
            // Address only follows the PC while fetching, so DROP keeps the old one.
            if (state_s == FETCH) begin
                addr_r <= pc_s;
            end
            if (capture_s) begin
                instr_r <= bus.imem_rdata;
                opc_r   <= pc_r;
            end
            if (xfer_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.imem_req  = req_r;
    assign bus.imem_addr = addr_r;
    assign bus.out_valid = valid_r;
    assign bus.out_pc    = opc_r;
    assign bus.out_instr = instr_r;
    assign bus.op        = instr_r[31:26];
    assign bus.rs        = instr_r[25:21];
    assign bus.rt        = instr_r[20:16];
    assign bus.rd        = instr_r[15:11];
    assign bus.shamt     = instr_r[10:6];
    assign bus.funct     = instr_r[5:0];
    assign bus.imm16     = instr_r[15:0];
    assign bus.fetch_cnt = cnt_r;
endmodule
